// File: rtl/cmp_result_tracker.sv
// cmp_result_tracker: G/E/L outcome counters, run tracking and a valid/ready snapshot (CMP_TRK_CLR_ON_SNAP_EN clears live counts on capture)
module cmp_result_tracker #(
  parameter int CNT_W = 8,
  parameter int RUN_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             G,
  input  logic             E,
  input  logic             L,
  input  logic             clr,
  input  logic             snap_req,
  input  logic             snap_ready,
  output logic             snap_valid,
  output logic [CNT_W-1:0] g_cnt,
  output logic [CNT_W-1:0] e_cnt,
  output logic [CNT_W-1:0] l_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [1:0]       last_code,
  output logic [RUN_W-1:0] run_len
);
  typedef enum logic {IDLE, HOLD} state_t;
  state_t state, state_nxt;
  logic [CNT_W-1:0] g_live, e_live, l_live, err_live;
  logic [CNT_W-1:0] g_base, e_base, l_base, err_base;
  logic [2:0] code;
  logic [1:0] code_enc;
  logic capture, wipe, legal;
  function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] c, input logic hit);
    return (hit && c != {CNT_W{1'b1}}) ? c + 1'b1 : c;
  endfunction
  assign code     = {G, E, L};
  assign code_enc = (code == 3'b100) ? 2'b10 : (code == 3'b010) ? 2'b11 : (code == 3'b001) ? 2'b01 : 2'b00;
  assign legal    = code_enc != 2'b00;
  assign capture  = (state == IDLE) && snap_req;
`ifdef CMP_TRK_CLR_ON_SNAP_EN
  assign wipe = capture;
`else
  assign wipe = 1'b0;
`endif
  assign g_base   = wipe ? '0 : g_live;
  assign e_base   = wipe ? '0 : e_live;
  assign l_base   = wipe ? '0 : l_live;
  assign err_base = wipe ? '0 : err_live;
  assign snap_valid = state == HOLD;
  always_comb begin
    state_nxt = state;
    state_nxt = (state == IDLE) ? (snap_req ? HOLD : IDLE) : (snap_ready ? IDLE : HOLD);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      g_live    <= '0;
      e_live    <= '0;
      l_live    <= '0;
      err_live  <= '0;
      g_cnt     <= '0;
      e_cnt     <= '0;
      l_cnt     <= '0;
      err_cnt   <= '0;
      last_code <= 2'b00;
      run_len   <= '0;
    end else begin
      state <= state_nxt;
      if (capture) begin
        g_cnt   <= g_live;
        e_cnt   <= e_live;
        l_cnt   <= l_live;
        err_cnt <= err_live;
      end
      if (clr) begin
        g_live    <= '0;
        e_live    <= '0;
        l_live    <= '0;
        err_live  <= '0;
        last_code <= 2'b00;
        run_len   <= '0;
      end else begin
        g_live   <= bump(g_base, in_valid && code_enc == 2'b10);
        e_live   <= bump(e_base, in_valid && code_enc == 2'b11);
        l_live   <= bump(l_base, in_valid && code_enc == 2'b01);
        err_live <= bump(err_base, in_valid && !legal);
        if (in_valid) begin
          last_code <= code_enc;
          run_len   <= !legal ? '0 : (code_enc != last_code) ? RUN_W'(1) : (run_len != {RUN_W{1'b1}}) ? run_len + 1'b1 : run_len;
        end
      end
    end
  end
endmodule

// File: tb/tb_cmp_result_tracker.sv
// tb_cmp_result_tracker: directed plus random stimulus against an integer reference model
module tb_cmp_result_tracker;
  localparam int CNT_W = 3;
  localparam int RUN_W = 2;
  localparam int CMAX = (1 << CNT_W) - 1;
  localparam int RMAX = (1 << RUN_W) - 1;
  localparam logic [2:0] CG = 3'b100;
  localparam logic [2:0] CE = 3'b010;
  localparam logic [2:0] CL = 3'b001;
`ifdef CMP_TRK_CLR_ON_SNAP_EN
  localparam bit CLR_SNAP = 1'b1;
`else
  localparam bit CLR_SNAP = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic g = 1'b0;
  logic e = 1'b0;
  logic l = 1'b0;
  logic clr = 1'b0;
  logic snap_req = 1'b0;
  logic snap_ready = 1'b0;
  logic snap_valid;
  logic [CNT_W-1:0] g_cnt, e_cnt, l_cnt, err_cnt;
  logic [1:0] last_code;
  logic [RUN_W-1:0] run_len;
  int errors = 0;
  int checks = 0;
  int mg, me, ml, merr, mrun, mlast, sg, se, sl, serr;
  bit hold;
  string phase = "reset";
  cmp_result_tracker #(.CNT_W(CNT_W), .RUN_W(RUN_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .G(g), .E(e), .L(l),
    .clr(clr), .snap_req(snap_req), .snap_ready(snap_ready), .snap_valid(snap_valid),
    .g_cnt(g_cnt), .e_cnt(e_cnt), .l_cnt(l_cnt), .err_cnt(err_cnt),
    .last_code(last_code), .run_len(run_len)
  );
  always #5 clk = ~clk;
  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction
  task automatic check(input string name, input logic [31:0] obs, input int exp);
    checks++;
    assert (obs === 32'(exp)) else begin
      errors++;
      $error("FAIL %s/%s observed=%0d expected=%0d", phase, name, obs, exp);
    end
  endtask
  task automatic tick();
    bit cap;
    int enc;
    @(posedge clk);
    if (!rst_n) begin
      {mg, me, ml, merr, mrun, mlast, sg, se, sl, serr} = '0;
      hold = 1'b0;
    end else begin
      cap = !hold && snap_req;
      if (cap) begin
        sg = mg; se = me; sl = ml; serr = merr;
      end
      hold = hold ? !snap_ready : snap_req;
      if (clr) begin
        {mg, me, ml, merr, mrun, mlast} = '0;
      end else begin
        if (cap && CLR_SNAP) {mg, me, ml, merr} = '0;
        if (in_valid) begin
          enc = ({g, e, l} == CG) ? 2 : ({g, e, l} == CE) ? 3 : ({g, e, l} == CL) ? 1 : 0;
          if (enc == 2) mg = sat(mg + 1, CMAX);
          if (enc == 3) me = sat(me + 1, CMAX);
          if (enc == 1) ml = sat(ml + 1, CMAX);
          if (enc == 0) merr = sat(merr + 1, CMAX);
          mrun = (enc == 0) ? 0 : (enc == mlast) ? sat(mrun + 1, RMAX) : 1;
          mlast = enc;
        end
      end
    end
    #1;
    check("snap_valid", 32'(snap_valid), int'(hold));
    check("g_cnt", 32'(g_cnt), sg);
    check("e_cnt", 32'(e_cnt), se);
    check("l_cnt", 32'(l_cnt), sl);
    check("err_cnt", 32'(err_cnt), serr);
    check("last_code", 32'(last_code), mlast);
    check("run_len", 32'(run_len), mrun);
    check("live_e", 32'(dut.e_live), me);
  endtask
  task automatic drive(input logic v, input logic [2:0] c, input logic cl, input logic rq, input logic rd);
    in_valid = v;
    {g, e, l} = c;
    clr = cl;
    snap_req = rq;
    snap_ready = rd;
    tick();
  endtask
  initial begin
    logic [2:0] rc;
    {mg, me, ml, merr, mrun, mlast, sg, se, sl, serr} = '0;
    hold = 1'b0;
    rst_n = 1'b0;
    drive(0, 3'b000, 0, 0, 0);
    drive(0, 3'b000, 0, 0, 0);
    rst_n = 1'b1;
    phase = "idle";
    drive(0, 3'b000, 0, 0, 0);
    drive(0, 3'b000, 0, 0, 0);
    phase = "count";
    drive(1, CG, 0, 0, 0);
    drive(1, CG, 0, 0, 0);
    drive(1, CG, 0, 0, 0);
    drive(1, CE, 0, 0, 0);
    drive(1, CL, 0, 0, 0);
    drive(1, CL, 0, 0, 0);
    drive(0, 3'b000, 0, 1, 1);
    drive(0, 3'b000, 0, 0, 1);
    drive(0, 3'b000, 0, 0, 0);
    phase = "illegal";
    drive(1, 3'b110, 0, 0, 0);
    drive(1, 3'b000, 0, 0, 0);
    drive(1, CE, 0, 0, 0);
    drive(0, 3'b000, 0, 1, 1);
    drive(0, 3'b000, 0, 0, 1);
    drive(0, 3'b000, 0, 0, 0);
    phase = "saturate";
    drive(0, 3'b000, 1, 0, 0);
    for (int i = 0; i < 10; i++) drive(1, CG, 0, 0, 0);
    drive(0, 3'b000, 0, 1, 1);
    drive(0, 3'b000, 0, 0, 1);
    drive(0, 3'b000, 0, 0, 0);
    phase = "hold";
    drive(1, CL, 0, 1, 0);
    for (int i = 0; i < 5; i++) drive(1, (i % 2 == 0) ? CE : CL, 0, 0, 0);
    rst_n = 1'b0;
    drive(1, CG, 0, 0, 0);
    rst_n = 1'b1;
    drive(0, 3'b000, 0, 0, 0);
    phase = "clr_snap";
    drive(0, 3'b000, 1, 0, 0);
    for (int i = 0; i < 4; i++) drive(1, CE, 0, 0, 0);
    drive(1, CE, 0, 1, 1);
    drive(0, 3'b000, 0, 0, 1);
    drive(0, 3'b000, 0, 0, 0);
    phase = "clr_with_req";
    drive(1, CG, 0, 0, 0);
    drive(1, CG, 1, 1, 0);
    drive(1, CG, 0, 0, 1);
    drive(0, 3'b000, 0, 0, 0);
    phase = "random";
    for (int i = 0; i < 400; i++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      rc = ($urandom_range(0, 7) < 6) ? ((($urandom_range(0, 2)) == 0) ? CG : ($urandom_range(0, 1) == 0) ? CE : CL) : 3'($urandom_range(0, 7));
      drive($urandom_range(0, 3) != 0, rc, $urandom_range(0, 19) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cmp_result_tracker.md
# cmp_result_tracker

Sequential consumer placed directly downstream of the 2-bit magnitude comparator. Each cycle it samples the comparator's one-hot G/E/L result, classifies it, and keeps per-outcome saturating counters. It also tracks an illegal-code counter and the run length of identical consecutive results. On request it presents a frozen snapshot of the counters over a valid/ready handshake.

## Interface
Parameters:
- CNT_W, 8, width of each outcome counter and of the error counter
- RUN_W, 4, width of the run-length counter

Ports:
- clk  in  1  single clock; all state updates on its rising edge
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  G/E/L carry a comparator result this cycle
- G  in  1  comparator A>B
- E  in  1  comparator A==B
- L  in  1  comparator A<B
- clr  in  1  synchronous clear of live counters and run tracking
- snap_req  in  1  request a snapshot of live counters
- snap_ready  in  1  consumer accepts the snapshot
- snap_valid  out  1  snapshot outputs valid
- g_cnt, e_cnt, l_cnt  out  CNT_W each  snapshot of the G/E/L counters
- err_cnt  out  CNT_W  snapshot of the illegal-code counter
- last_code  out  2  last legal result, live: 00 none, 01 L, 10 G, 11 E
- run_len  out  RUN_W  live count of consecutive identical legal results

## Operation
- Reset: when rst_n=0 at a clock edge, every output and internal register goes to 0 and the FSM enters IDLE.
- Classification applies only when in_valid=1. {G,E,L}=100 increments G; 010 increments E; 001 increments L; any other code increments err.
- All counters saturate at 2^CNT_W-1 and never wrap.
- Run tracking:
  - A legal result equal to last_code increments run_len, saturating at 2^RUN_W-1.
  - A legal result different from last_code sets run_len=1 and updates last_code.
  - An illegal result sets run_len=0 and last_code=00.
  - When in_valid=0, run state is unchanged.
- clr=1 zeroes live counters, run_len and last_code. clr takes priority over any same-cycle increment; that cycle's sample is dropped.
- FSM has two states, IDLE and HOLD:
  - IDLE: snap_valid=0. If snap_req=1, copy the live counters into the snapshot registers and go to HOLD.
  - HOLD: snap_valid=1 and the snapshot registers are frozen. When snap_valid and snap_ready are both 1, return to IDLE. snap_req is ignored in HOLD.
- The snapshot captures live values as registered before the capture edge; the sample at that same edge is not included.
- If snap_req and clr coincide, the snapshot holds pre-clear values.
- Live counters keep counting while in HOLD.
- Reset while in HOLD drops the snapshot: snap_valid=0 and all snapshot registers are 0.

## Timing
- Counter, run_len and last_code updates are visible 1 cycle after the sampled edge.
- snap_valid rises 1 cycle after snap_req is sampled in IDLE.
- snap_valid falls 1 cycle after the handshake edge. The earliest next capture is the cycle after the FSM returns to IDLE, giving a minimum of 2 cycles between snapshots.
- No combinational path from any input to any output; all outputs are registered.

## Configuration
- Macro CMP_TRK_CLR_ON_SNAP_EN.
- Defined: the capture edge also resets the live counters (g/e/l/err). Any same-cycle valid sample lands in the fresh counter as 1, so no sample is lost. run_len and last_code are unaffected.
- Undefined: the capture edge leaves the live counters untouched, and counts accumulate from reset or the last clr.

## Test plan
- Reset and idle: hold rst_n=0 for 2 cycles, then release with in_valid=0 -> all outputs 0, snap_valid=0.
- Counting and run: send G,G,G,E,L,L (valid every cycle), then snap_req with snap_ready=1 -> g_cnt=3, e_cnt=1, l_cnt=2, err_cnt=0; live run_len=2, last_code=01; snap_valid high for exactly 1 cycle.
- Illegal code: send 110, then 000, then E -> err_cnt=2. run_len goes 0, 0, then 1; last_code ends at 11.
- Saturation: CNT_W=3, RUN_W=2; send 10 consecutive G -> g_cnt snapshot=7, run_len=3.
- Handshake hold and mid-operation reset: snap_req with snap_ready=0 for 5 cycles while new samples arrive -> snapshot values stay constant. Then assert rst_n=0 -> snap_valid=0 next cycle, all counts 0.
- Clear-on-snap: with CMP_TRK_CLR_ON_SNAP_EN, 4 E samples, then snap_req plus an E in the same cycle -> snapshot e_cnt=4, live e_cnt=1. Without the macro, live e_cnt=5.
